// File: rtl/frame_ptr_unit.sv
// Frame-pointer unit: holds ebp and a shadow stack of saved frame pointers,
// driven by LOAD/ENTER/LEAVE commands with sticky overflow/underflow halting.
module frame_ptr_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = 32'h0000_0999
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [WIDTH-1:0]             cmd_data,
  input  logic                         clear_err,
  output logic [WIDTH-1:0]             ebp,
  output logic [WIDTH-1:0]             prev_ebp,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         full,
  output logic                         empty,
  output logic                         err_overflow,
  output logic                         err_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(DEPTH+1);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_ENTER = 2'b10;
  localparam logic [1:0] OP_LEAVE = 2'b11;

  typedef enum logic {IDLE, HALT} state_t;

  state_t           state;
  logic [WIDTH-1:0] stack [DEPTH];
  logic             accept;
  logic             push;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign full      = (depth == DW'(DEPTH));
  assign empty     = (depth == '0);
  assign prev_ebp  = empty ? '0 : stack[AW'(depth - DW'(1))];
  assign push      = !reset && accept && (cmd_op == OP_ENTER) && !full;

  // NOTE: the shadow stack is plain storage with no reset; depth alone says
  // which entries are valid, so clearing the array would only cost a reset net.
  always_ff @(posedge clock) begin
    if (push) stack[AW'(depth)] <= ebp;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values (e.g. push above reads the old ebp being replaced).
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      ebp           <= RESET_VALUE;
      depth         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (cmd_op)
              OP_LOAD: ebp <= cmd_data;
              OP_ENTER: begin
                if (!full) begin
                  ebp   <= cmd_data;
                  depth <= depth + DW'(1);
                end else begin
                  err_overflow <= 1'b1;
                  state        <= HALT;
                end
              end
              OP_LEAVE: begin
                if (!empty) begin
                  ebp   <= prev_ebp;
                  depth <= depth - DW'(1);
                end else begin
                  err_underflow <= 1'b1;
                  state         <= HALT;
                end
              end
              default: ;
            endcase
          end
        end
        HALT: begin
          // Commands offered alongside clear_err are dropped: cmd_ready is low here.
          if (clear_err) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/frame_ptr_unit.md
FRAME_PTR_UNIT -- requirements
Module: frame_ptr_unit

Interface
REQ-001 Parameter WIDTH, default 32, width of the frame pointer and of every saved entry.
REQ-002 Parameter DEPTH, default 8, number of saved-frame entries in the internal shadow stack (DEPTH >= 2).
REQ-003 Parameter RESET_VALUE, default 32'h0000_0999, value loaded into ebp on reset.
REQ-004 clock  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 cmd_valid  input  1  a command is offered this cycle.
REQ-007 cmd_ready  output  1  the unit can accept a command this cycle.
REQ-008 cmd_op  input  2  2'b00 NOP, 2'b01 LOAD, 2'b10 ENTER, 2'b11 LEAVE.
REQ-009 cmd_data  input  WIDTH  new frame pointer for LOAD and ENTER; ignored otherwise.
REQ-010 clear_err  input  1  leave the HALT state.
REQ-011 ebp  output  WIDTH  current frame pointer, registered.
REQ-012 prev_ebp  output  WIDTH  top shadow-stack entry; 0 when empty.
REQ-013 depth  output  $clog2(DEPTH+1)  number of valid shadow-stack entries.
REQ-014 full / empty  output  1 each  depth==DEPTH / depth==0.
REQ-015 err_overflow / err_underflow  output  1 each  sticky error flags.

Function
REQ-016 The unit SHALL have two states: IDLE (cmd_ready=1) and HALT (cmd_ready=0).
REQ-017 A command SHALL be accepted only when cmd_valid && cmd_ready; it takes effect at that edge, and the outputs update the following cycle (1-cycle latency).
REQ-018 NOP SHALL change no state.
REQ-019 LOAD SHALL set ebp <= cmd_data; depth and the stack SHALL be unchanged.
REQ-020 ENTER when not full SHALL write the old ebp to stack[depth], set ebp <= cmd_data, and increment depth, all in the same edge.
REQ-021 LEAVE when not empty SHALL set ebp <= stack[depth-1] and decrement depth.
REQ-022 ENTER when full SHALL leave ebp, depth and the stack unchanged, set err_overflow and move to HALT.
REQ-023 LEAVE when empty SHALL leave ebp and depth unchanged, set err_underflow and move to HALT.
REQ-024 In HALT, no command SHALL be accepted; cmd_valid is ignored.
REQ-025 clear_err in HALT SHALL clear both error flags and return to IDLE at the next edge.
REQ-026 ebp, depth and the stack SHALL be preserved across HALT.
REQ-027 A command offered in the same cycle as clear_err in HALT SHALL NOT be accepted.
REQ-028 clear_err in IDLE SHALL have no effect.
REQ-029 prev_ebp SHALL equal stack[depth-1] when depth>0, and 0 otherwise.
REQ-030 Depth arithmetic SHALL never wrap; the guards in REQ-022 and REQ-023 are the only bound checks.
REQ-031 full, empty and prev_ebp SHALL be derived from registered state with no combinational path from cmd_* inputs.
REQ-032 Only cmd_ready may depend combinationally on state.

Reset
REQ-033 reset SHALL set ebp=RESET_VALUE, depth=0, state=IDLE and err_overflow=err_underflow=0.
REQ-034 After reset, prev_ebp=0, empty=1 and full=0.
REQ-035 Shadow-stack contents SHALL NOT be reset.
REQ-036 reset SHALL override any command or clear_err in the same cycle, including mid-HALT.

Verification
REQ-037 Reset, then idle -> ebp=32'h0000_0999, depth=0, empty=1, cmd_ready=1.
REQ-038 LOAD 32'h100; ENTER 32'h200 -> ebp=32'h200, prev_ebp=32'h100, depth=1; LEAVE -> ebp=32'h100, depth=0, empty=1.
REQ-039 8 back-to-back ENTERs with data 1..8 from ebp=32'hA -> full=1, ebp=8, prev_ebp=7; a 9th ENTER -> err_overflow=1, cmd_ready=0, ebp=8, depth=8.
REQ-040 LEAVE at depth=0 -> err_underflow=1 and HALT; LOAD offered during HALT -> ebp unchanged.
REQ-041 clear_err with cmd_valid (LOAD 32'h55) in HALT -> LOAD not accepted; flags=0 and cmd_ready=1 next cycle; LOAD is then accepted, giving ebp=32'h55.
REQ-042 From HALT at depth=3, assert reset -> all values per REQ-033; a subsequent LEAVE -> underflow.
